dmem_bus_adapter: RTL and testbench
===================================

Name: dmem_bus_adapter

Overview:
- Sits directly downstream of the pipelined datapath's MEM-stage data-memory port.
- Converts the single-cycle dmem request (addr/wdata/byteen/we/re) into a registered valid/ready request and response bus transaction.
- Raises a pipeline stall until the response returns, then presents load data and a bus-error flag for one cycle.
- Contains a watchdog so a hung bus cannot deadlock the core.

Parameters:
WIDTH, 32, data/address width
TIMEOUT_CYCLES, 256, max cycles waiting in WAIT_RSP before forced error completion (must be >=2)

Ports:
i_clk  input  1  core clock
i_reset_n  input  1  asynchronous active-low reset
i_addr  input  WIDTH  request address from datapath
i_wdata  input  WIDTH  store data (already lane-aligned)
i_byteen  input  4  store byte enables
i_we  input  1  store request
i_re  input  1  load request
o_rdata  output  WIDTH  load data to datapath, valid when o_done=1
o_done  output  1  one-cycle access-complete pulse
o_err  output  1  error/timeout flag, valid with o_done
o_stall  output  1  freeze IF..MEM pipeline registers and PC
o_bus_req_valid  output  1  bus request valid
i_bus_req_ready  input  1  bus accepts request
o_bus_addr  output  WIDTH  registered address
o_bus_wdata  output  WIDTH  registered store data
o_bus_byteen  output  4  registered byte enables (4'b0000 for loads)
o_bus_we  output  1  1=write, 0=read
i_bus_rsp_valid  input  1  response valid
i_bus_rsp_data  input  WIDTH  read data (ignored for writes)
i_bus_rsp_err  input  1  slave error

Behaviour:
- Reset (async, i_reset_n=0): state=IDLE, all outputs 0, watchdog=0. Reset mid-transaction abandons it; no response is later consumed.
- Request: req = i_we | i_re. If both are high, the write wins (o_bus_we=1).
- o_stall is combinational: (state==IDLE & req) | state==REQ | state==WAIT_RSP. It is 0 in IDLE with no request and 0 in DONE.
- IDLE:
  - On req, latch addr/wdata/byteen/we into the bus output registers, then go to REQ.
  - Loads drive byteen=0 and wdata=0.
- REQ:
  - o_bus_req_valid=1; payload is held stable until the handshake.
  - On valid&ready, go to WAIT_RSP and clear the watchdog.
  - There is no abort path.
- WAIT_RSP:
  - o_bus_req_valid=0; watchdog increments each cycle.
  - On i_bus_rsp_valid, capture rdata (loads only; writes capture 0) and err, then go to DONE.
  - If the watchdog reaches TIMEOUT_CYCLES-1 without a response, go to DONE with err=1 and rdata=0.
  - A response and expiry in the same cycle: the response wins.
- DONE:
  - o_done=1 for exactly one cycle; o_rdata/o_err are valid and o_stall=0, so the pipeline advances on this edge.
  - Unconditionally go to IDLE. The stale request still visible in DONE is never reissued.
- i_bus_rsp_valid outside WAIT_RSP is ignored. The bus guarantees a response no earlier than the cycle after the handshake.
- Latency with a zero-wait bus (ready=1, response one cycle after the handshake): stall for 3 cycles, o_done in the 4th cycle.
- Back-to-back: a new request is accepted in the IDLE cycle immediately after DONE.
- o_rdata holds its last value outside DONE. Consumers qualify it with o_done.
- Watchdog width is $clog2(TIMEOUT_CYCLES); no wraparound is possible because the state leaves WAIT_RSP on expiry.

Decomposition:
- Shared package dmem_bus_pkg: state enum dbus_state_t {IDLE, REQ, WAIT_RSP, DONE}, and a packed struct dbus_req_t {addr, wdata, byteen, we}.
- The core's RISC-V opcode defs are untouched.
- Sub-module: dbus_watchdog. Inputs are clear, enable and the TIMEOUT_CYCLES parameter; output is expired. Same asynchronous active-low reset.

Test Plan:
- Load, zero-wait bus, addr=0x0000_1004, rsp_data=0xDEAD_BEEF -> o_stall high for cycles 0-2, o_done=1 in cycle 3 with o_rdata=0xDEADBEEF, o_err=0, bus byteen=0, we=0.
- Store, wdata=0x1234_5678, byteen=4'b0011, ready held low for 5 cycles -> valid high and payload constant across all 5 cycles, handshake on cycle 6, done after the response, o_rdata=0.
- re=we=1 simultaneously -> a single write transaction issued, o_bus_we=1.
- No response, TIMEOUT_CYCLES=8 -> o_done with o_err=1 and o_rdata=0 exactly 8 cycles after entering WAIT_RSP; o_stall drops that cycle.
- i_reset_n pulsed low in WAIT_RSP, then a late rsp_valid -> outputs go to 0 immediately, state=IDLE, the late response is ignored, and a following load completes normally.
- Back-to-back load then store with rsp_err=1 on the store -> the second request is issued the cycle after the first DONE, and the second o_done carries o_err=1.

Source files
------------

// File: rtl/dmem_bus_pkg.sv
// Purpose : shared types for the MEM-stage data-memory bus adapter.
// Latency : n/a (types, constants and a payload helper only).
// Backpr. : n/a.
package dmem_bus_pkg;

    localparam int DBUS_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } dbus_state_t;

    typedef struct packed {
        logic [DBUS_WIDTH-1:0] addr;
        logic [DBUS_WIDTH-1:0] wdata;
        logic [3:0]            byteen;
        logic                  we;
    } dbus_req_t;

    // Builds the bus payload from the raw dmem port. Loads never carry
    // store data or byte enables onto the bus, so the slave can key off
    // we alone and see clean zeros otherwise.
    function automatic dbus_req_t dbus_make_req(
        input logic [DBUS_WIDTH-1:0] addr,
        input logic [DBUS_WIDTH-1:0] wdata,
        input logic [3:0]            byteen,
        input logic                  we
    );
        dbus_req_t r;
        r.addr   = addr;
        r.wdata  = we ? wdata  : '0;
        r.byteen = we ? byteen : 4'b0000;
        r.we     = we;
        return r;
    endfunction

endpackage

// File: rtl/dbus_watchdog.sv
// Purpose : cycle counter that flags a bus response as overdue.
// Latency : expired is combinational from the count; count updates each enabled cycle.
// Backpr. : none; the count freezes once expired so it never wraps.
//
// Ports:
//   i_clk, i_reset_n : core clock, asynchronous active-low reset
//   clear            : restart the count at zero (takes priority over enable)
//   enable           : count this cycle
//   expired          : count has reached TIMEOUT_CYCLES-1 while enabled
module dbus_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int                CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    assign expired = enable && (count == LAST);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dmem_bus_adapter.sv
// Purpose : turns the single-cycle MEM-stage dmem request into a registered valid/ready bus transaction.
// Latency : zero-wait bus gives 3 stall cycles, o_done in the 4th; watchdog forces completion after TIMEOUT_CYCLES.
// Backpr. : o_stall freezes the pipeline from request until DONE; payload is held stable while ready is low.
//
// Ports:
//   i_clk, i_reset_n              : core clock, asynchronous active-low reset
//   i_addr/i_wdata/i_byteen       : dmem request payload from the datapath
//   i_we, i_re                    : store / load request (store wins if both)
//   o_rdata, o_done, o_err        : completion pulse with load data and error flag
//   o_stall                       : freeze IF..MEM registers and PC
//   o_bus_req_valid/i_bus_req_ready, o_bus_addr/wdata/byteen/we : request channel
//   i_bus_rsp_valid/data/err      : response channel
module dmem_bus_adapter
    import dmem_bus_pkg::*;
#(
    parameter int WIDTH          = DBUS_WIDTH,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [WIDTH-1:0] i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [3:0]       i_byteen,
    input  logic             i_we,
    input  logic             i_re,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_done,
    output logic             o_err,
    output logic             o_stall,
    output logic             o_bus_req_valid,
    input  logic             i_bus_req_ready,
    output logic [WIDTH-1:0] o_bus_addr,
    output logic [WIDTH-1:0] o_bus_wdata,
    output logic [3:0]       o_bus_byteen,
    output logic             o_bus_we,
    input  logic             i_bus_rsp_valid,
    input  logic [WIDTH-1:0] i_bus_rsp_data,
    input  logic             i_bus_rsp_err
);

    dbus_state_t      state, state_nxt;
    dbus_req_t        req_q;
    logic [WIDTH-1:0] rdata_q;
    logic             err_q;
    logic             dmem_req_vld;
    logic             wd_clear, wd_enable, wd_expired;

    assign dmem_req_vld = i_we | i_re;

    dbus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .clear     (wd_clear),
        .enable    (wd_enable),
        .expired   (wd_expired)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. DONE ignores the request still present on the dmem
    // port: the pipeline advances on that edge, so whatever is visible then
    // is the already-serviced access.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (dmem_req_vld)                   state_nxt = REQ;
            REQ:      if (i_bus_req_ready)                state_nxt = WAIT_RSP;
            WAIT_RSP: if (i_bus_rsp_valid || wd_expired)  state_nxt = DONE;
            DONE:                                         state_nxt = IDLE;
            default:                                      state_nxt = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        o_stall         = 1'b0;
        o_done          = 1'b0;
        o_bus_req_valid = 1'b0;
        o_err           = 1'b0;
        wd_clear        = 1'b0;
        wd_enable       = 1'b0;
        case (state)
            IDLE: begin
                // Stall in the same cycle the request appears so the
                // MEM-stage instruction is held while the payload registers.
                o_stall = dmem_req_vld;
            end
            REQ: begin
                o_stall         = 1'b1;
                o_bus_req_valid = 1'b1;
                wd_clear        = i_bus_req_ready;
            end
            WAIT_RSP: begin
                o_stall   = 1'b1;
                wd_enable = 1'b1;
            end
            DONE: begin
                o_done = 1'b1;
                o_err  = err_q;
            end
            default: begin
                o_stall = 1'b0;
            end
        endcase
    end

    // Payload and response capture
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && dmem_req_vld) begin
                req_q <= dbus_make_req(i_addr, i_wdata, i_byteen, i_we);
            end
            if (state == WAIT_RSP) begin
                // A response in the expiry cycle still counts as a real response.
                if (i_bus_rsp_valid) begin
                    rdata_q <= req_q.we ? '0 : i_bus_rsp_data;
                    err_q   <= i_bus_rsp_err;
                end else if (wd_expired) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign o_rdata      = rdata_q;
    assign o_bus_addr   = req_q.addr;
    assign o_bus_wdata  = req_q.wdata;
    assign o_bus_byteen = req_q.byteen;
    assign o_bus_we     = req_q.we;

endmodule

// File: tb/tb_dmem_bus_adapter.sv
// Purpose : self-checking bench for dmem_bus_adapter with a reactive bus slave and a transaction-level model.
// Latency : n/a.
// Backpr. : slave throttles ready and response timing per transaction.
module tb_dmem_bus_adapter;

    localparam int W = 32;
    localparam int T = 8;

    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic [W-1:0]  i_addr, i_wdata;
    logic [3:0]    i_byteen;
    logic          i_we, i_re;
    logic [W-1:0]  o_rdata;
    logic          o_done, o_err, o_stall;
    logic          o_bus_req_valid;
    logic          i_bus_req_ready;
    logic [W-1:0]  o_bus_addr, o_bus_wdata;
    logic [3:0]    o_bus_byteen;
    logic          o_bus_we;
    logic          i_bus_rsp_valid;
    logic [W-1:0]  i_bus_rsp_data;
    logic          i_bus_rsp_err;

    always #5 i_clk = ~i_clk;

    dmem_bus_adapter #(
        .WIDTH          (W),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .i_clk           (i_clk),
        .i_reset_n       (i_reset_n),
        .i_addr          (i_addr),
        .i_wdata         (i_wdata),
        .i_byteen        (i_byteen),
        .i_we            (i_we),
        .i_re            (i_re),
        .o_rdata         (o_rdata),
        .o_done          (o_done),
        .o_err           (o_err),
        .o_stall         (o_stall),
        .o_bus_req_valid (o_bus_req_valid),
        .i_bus_req_ready (i_bus_req_ready),
        .o_bus_addr      (o_bus_addr),
        .o_bus_wdata     (o_bus_wdata),
        .o_bus_byteen    (o_bus_byteen),
        .o_bus_we        (o_bus_we),
        .i_bus_rsp_valid (i_bus_rsp_valid),
        .i_bus_rsp_data  (i_bus_rsp_data),
        .i_bus_rsp_err   (i_bus_rsp_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // One complete access. Called at negedge+1 with the DUT in IDLE; returns
    // at negedge+1 of the DONE cycle with the request still held on the port.
    // rdy_dly: valid cycles with ready low before acceptance.
    // rsp_dly: cycles after the handshake cycle before the response; a value
    //          of T or more means the slave never answers.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic we, input logic re,
                           input int rdy_dly, input int rsp_dly,
                           input logic [31:0] rdat, input logic rerr);
        logic [31:0] exp_wdata, exp_rdata;
        logic [3:0]  exp_be;
        logic        exp_err;
        int          exp_stall;
        int          rdy_cnt, wait_cnt, stall_cnt, cyc;
        bit          hs, done_seen;

        exp_wdata = we ? wdata : 32'h0;
        exp_be    = we ? be : 4'h0;
        if (rsp_dly < T) begin
            exp_rdata = we ? 32'h0 : rdat;
            exp_err   = rerr;
            exp_stall = 1 + (rdy_dly + 1) + (rsp_dly + 1);
        end else begin
            exp_rdata = 32'h0;
            exp_err   = 1'b1;
            exp_stall = 1 + (rdy_dly + 1) + T;
        end

        rdy_cnt = 0; wait_cnt = 0; stall_cnt = 0; cyc = 0;
        hs = 1'b0; done_seen = 1'b0;

        i_addr = addr; i_wdata = wdata; i_byteen = be; i_we = we; i_re = re;
        i_bus_req_ready = 1'b0;
        i_bus_rsp_valid = 1'b0;
        #1;
        while (!done_seen && cyc < 200) begin
            if (o_done) begin
                done_seen = 1'b1;
                check_eq("rdata",        o_rdata, exp_rdata);
                check_eq("err",          o_err, exp_err);
                check_eq("done_stall",   o_stall, 1'b0);
                check_eq("done_valid",   o_bus_req_valid, 1'b0);
                check_eq("stall_cycles", stall_cnt, exp_stall);
                // Stray response while in DONE must not be consumed.
                i_bus_req_ready = 1'b0;
                i_bus_rsp_valid = 1'($urandom_range(0, 1));
                i_bus_rsp_data  = $urandom;
                i_bus_rsp_err   = 1'b1;
            end else begin
                stall_cnt++;
                check_eq("stall", o_stall, 1'b1);
                if (hs) check_eq("valid_after_hs", o_bus_req_valid, 1'b0);
                if (o_bus_req_valid) begin
                    check_eq("bus_addr",   o_bus_addr, addr);
                    check_eq("bus_wdata",  o_bus_wdata, exp_wdata);
                    check_eq("bus_byteen", o_bus_byteen, exp_be);
                    check_eq("bus_we",     o_bus_we, we);
                end
                i_bus_req_ready = o_bus_req_valid ? (rdy_cnt == rdy_dly)
                                                  : 1'($urandom_range(0, 1));
                if (hs) begin
                    i_bus_rsp_valid = (wait_cnt == rsp_dly);
                    i_bus_rsp_data  = (wait_cnt == rsp_dly) ? rdat : $urandom;
                    i_bus_rsp_err   = (wait_cnt == rsp_dly) ? rerr : 1'($urandom_range(0, 1));
                    wait_cnt++;
                end else begin
                    i_bus_rsp_valid = 1'($urandom_range(0, 1));
                    i_bus_rsp_data  = $urandom;
                    i_bus_rsp_err   = 1'($urandom_range(0, 1));
                end
                if (o_bus_req_valid) begin
                    if (i_bus_req_ready) hs = 1'b1;
                    rdy_cnt++;
                end
                @(negedge i_clk); #1;
            end
            cyc++;
        end
        check_eq("done_seen", done_seen, 1'b1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk); #1;
            i_we = 1'b0; i_re = 1'b0;
            i_bus_req_ready = 1'($urandom_range(0, 1));
            i_bus_rsp_valid = 1'($urandom_range(0, 1));
            i_bus_rsp_data  = $urandom;
            #1;
            check_eq("idle_stall", o_stall, 1'b0);
            check_eq("idle_valid", o_bus_req_valid, 1'b0);
            check_eq("idle_done",  o_done, 1'b0);
        end
    endtask

    initial begin
        int          sel, rdy, rsp;
        logic        we_r, re_r;

        i_reset_n = 1'b0;
        i_addr = '0; i_wdata = '0; i_byteen = '0; i_we = 1'b0; i_re = 1'b0;
        i_bus_req_ready = 1'b0; i_bus_rsp_valid = 1'b0;
        i_bus_rsp_data = '0; i_bus_rsp_err = 1'b0;
        repeat (2) @(negedge i_clk);
        #1;
        check_eq("rst_stall", o_stall, 1'b0);
        check_eq("rst_done",  o_done, 1'b0);
        check_eq("rst_valid", o_bus_req_valid, 1'b0);
        check_eq("rst_rdata", o_rdata, 32'h0);
        check_eq("rst_err",   o_err, 1'b0);
        check_eq("rst_addr",  o_bus_addr, 32'h0);
        i_reset_n = 1'b1;

        // Load on a zero-wait bus: 3 stall cycles, done in the 4th.
        @(negedge i_clk); #1;
        run_txn(32'h0000_1004, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 0, 0, 32'hDEAD_BEEF, 1'b0);
        idle_cycles(1);

        // Reset while waiting for a response, then a late response.
        @(negedge i_clk); #1;
        i_addr = 32'h0000_2000; i_re = 1'b1; i_we = 1'b0;
        i_bus_req_ready = 1'b1; i_bus_rsp_valid = 1'b0;
        @(negedge i_clk); #1;
        check_eq("rstw_req_valid", o_bus_req_valid, 1'b1);
        @(negedge i_clk); #1;
        check_eq("rstw_wait_valid", o_bus_req_valid, 1'b0);
        check_eq("rstw_wait_stall", o_stall, 1'b1);
        i_reset_n = 1'b0; i_re = 1'b0; i_bus_req_ready = 1'b0;
        #1;
        check_eq("rstw_stall", o_stall, 1'b0);
        check_eq("rstw_done",  o_done, 1'b0);
        check_eq("rstw_valid", o_bus_req_valid, 1'b0);
        check_eq("rstw_addr",  o_bus_addr, 32'h0);
        check_eq("rstw_rdata", o_rdata, 32'h0);
        check_eq("rstw_err",   o_err, 1'b0);
        @(negedge i_clk); #1;
        i_reset_n = 1'b1;
        i_bus_rsp_valid = 1'b1; i_bus_rsp_data = 32'hBAD0_BAD0; i_bus_rsp_err = 1'b1;
        @(negedge i_clk); #1;
        check_eq("late_done",  o_done, 1'b0);
        check_eq("late_stall", o_stall, 1'b0);
        i_bus_rsp_valid = 1'b0;
        @(negedge i_clk); #1;
        check_eq("late_done2", o_done, 1'b0);
        check_eq("late_rdata", o_rdata, 32'h0);
        @(negedge i_clk); #1;
        run_txn(32'h0000_3008, 32'h0, 4'h0, 1'b0, 1'b1, 1, 2, 32'hCAFE_F00D, 1'b0);
        idle_cycles(1);

        // Store with ready held low for 5 valid cycles.
        @(negedge i_clk); #1;
        run_txn(32'h0000_4000, 32'h1234_5678, 4'b0011, 1'b1, 1'b0, 5, 0, 32'h5555_AAAA, 1'b0);
        idle_cycles(1);

        // Load and store together: a single write.
        @(negedge i_clk); #1;
        run_txn(32'h0000_5010, 32'hA5A5_5A5A, 4'b1100, 1'b1, 1'b1, 0, 1, 32'h7777_7777, 1'b0);
        idle_cycles(1);

        // Silent slave: watchdog forces error completion.
        @(negedge i_clk); #1;
        run_txn(32'h0000_6000, 32'h0, 4'h0, 1'b0, 1'b1, 0, T + 5, 32'h1111_1111, 1'b0);
        idle_cycles(1);

        // Response in the expiry cycle wins over the watchdog.
        @(negedge i_clk); #1;
        run_txn(32'h0000_6004, 32'h0, 4'h0, 1'b0, 1'b1, 2, T - 1, 32'h2468_ACE0, 1'b0);

        // Back-to-back: load then store with slave error.
        @(negedge i_clk); #1;
        run_txn(32'h0000_7000, 32'h0, 4'h0, 1'b0, 1'b1, 0, 0, 32'h0BAD_C0DE, 1'b0);
        @(negedge i_clk); #1;
        run_txn(32'h0000_7004, 32'hFEED_FACE, 4'hF, 1'b1, 1'b0, 0, 0, 32'h0, 1'b1);
        idle_cycles(2);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            sel  = $urandom_range(0, 2);
            we_r = (sel != 0);
            re_r = (sel != 1);
            rdy  = $urandom_range(0, 4);
            rsp  = $urandom_range(0, T + 1);
            @(negedge i_clk); #1;
            run_txn($urandom, $urandom, 4'($urandom), we_r, re_r, rdy, rsp,
                    $urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 2));
        end
        idle_cycles(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
